// File: rtl/uart_rx_fifo_if.sv
// Receive-path bus between the UART front end and the RX byte consumer.
// Latency: none, wires only.
// Backpressure: the consumer pops with rd_en; when the FIFO is full, arriving bytes are dropped and flagged with overrun.
// Ports: rx (serial line into the front end), rd_en (pop strobe from the consumer),
//        rd_data/empty/full/count (show-ahead FIFO view), rx_done/frame_err/overrun (one-cycle status pulses).
interface uart_rx_fifo_if #(
  parameter int DEPTH = 4
);
  logic                   rx;
  logic                   rd_en;
  logic [7:0]             rd_data;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   rx_done;
  logic                   frame_err;
  logic                   overrun;

  // master: the UART receiver / FIFO side
  modport master (
    input  rx, rd_en,
    output rd_data, empty, full, count, rx_done, frame_err, overrun
  );

  // slave: the line driver plus the byte consumer
  modport slave (
    output rx, rd_en,
    input  rd_data, empty, full, count, rx_done, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a small show-ahead byte FIFO.
// Latency: a byte is pushed on the stop-sample tick, 152 ticks after the start edge is seen (+2 sync clocks, +<=DIV alignment).
// Backpressure: none toward the line; a full FIFO drops good bytes (overrun) unless rd_en pops in the same cycle.
// Ports: clk_100MHz (system clock), reset (async, active-high), bus (uart_rx_fifo_if.master:
//        rx in, rd_en in, rd_data/empty/full/count out, rx_done/frame_err/overrun pulses out).
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  uart_rx_fifo_if.master bus
);
  localparam int DIV = CLK_FREQ / (16 * BAUD);
  localparam int TW  = $clog2(DIV);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    s_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic          stop_sample;
  logic          push;
  logic          pop;
  logic          drop_ovr;
  logic          drop_ferr;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  logic          rx_done_r;
  logic          frame_err_r;
  logic          overrun_r;

  // Two-flop synchroniser, reset to the idle line level so no false start edge follows reset.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Oversample tick: one pulse every DIV clocks.
  assign tick = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; the FSM only moves on tick cycles
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        IDLE:    if (!rx_s) state_nxt = START;
        // 8th tick in START is the middle of the start bit; high there means it was a glitch
        START:   if (s_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
        DATA:    if ((s_cnt == 4'd15) && (bit_idx == 3'd7)) state_nxt = STOP;
        STOP:    if (s_cnt == 4'd15) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: stop-bit verdict and the FIFO push decision
  always_comb begin
    stop_sample = tick && (state == STOP) && (s_cnt == 4'd15);
    // A full FIFO still takes the byte if the consumer pops in the same cycle.
    push        = stop_sample && rx_s && (!full || bus.rd_en);
    drop_ovr    = stop_sample && rx_s && full && !bus.rd_en;
    drop_ferr   = stop_sample && !rx_s;
  end

  // Bit-timing counters and shift register. s_cnt is 4 bits so it wraps to 0 at the
  // end of each 16-tick bit period in DATA/STOP without extra logic.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      s_cnt   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          s_cnt <= '0;
        end
        START: begin
          s_cnt   <= (s_cnt == 4'd7) ? 4'd0 : s_cnt + 4'd1;
          bit_idx <= '0;
        end
        DATA: begin
          s_cnt <= s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            // LSB arrives first, so shifting right leaves it in bit 0 after 8 bits
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          s_cnt <= s_cnt + 4'd1;
        end
        default: begin
          s_cnt <= '0;
        end
      endcase
    end
  end

  // Status pulses, registered on the stop-sample edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      rx_done_r   <= push;
      frame_err_r <= drop_ferr;
      overrun_r   <= drop_ovr;
    end
  end

  // FIFO
  assign pop   = bus.rd_en && !empty;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage is deliberately left unreset; rd_data is masked while empty.
  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.rd_data   = empty ? 8'h00 : mem[rd_ptr];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.rx_done   = rx_done_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;
endmodule
